airplane_draw_ctrl: RTL and testbench

//  FSM that sequences the 4x4 sprite datapath (position/colour registers + x/y pixel counters) to animate the plane.
//  Per frame: load position and colour, draw 16 pixels, hold, erase with background colour, apply up/down motion.

---
 rtl/airplane_draw_ctrl.sv | 117 +++++++++++
 tb/tb_airplane_draw_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/airplane_draw_ctrl.sv
// Sequencer for the 4x4 plane sprite: load, draw, hold, erase, move, repeat while go is high.
// State  | meaning
// IDLE   | waiting for go, all strobes low
// LOAD_D | load x/y/draw colour into the datapath
// DRAW   | 16 plot cycles in draw colour
// WAIT   | hold the drawn frame for FRAME_TICKS cycles
// LOAD_E | reload colour register with background
// ERASE  | 16 plot cycles in background colour
// UPDATE | apply up/down motion, decide on next frame
module airplane_draw_ctrl #(
  parameter logic [8:0]  X_START     = 9'd40,
  parameter logic [7:0]  Y_START     = 8'd56,
  parameter logic [7:0]  Y_MIN       = 8'd0,
  parameter logic [7:0]  Y_MAX       = 8'd116,
  parameter logic [7:0]  STEP        = 8'd1,
  parameter logic [2:0]  PLANE_COLOR = 3'b111,
  parameter logic [23:0] FRAME_TICKS = 24'd833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic       up,
  input  logic       down,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_color,
  output logic       dp_enable,
  output logic       plot,
  output logic [8:0] x_in,
  output logic [7:0] y_in,
  output logic [2:0] color_in,
  output logic       busy,
  output logic [7:0] plane_y
);

  typedef enum logic [2:0] {IDLE, LOAD_D, DRAW, WAIT, LOAD_E, ERASE, UPDATE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  pix_cnt, pix_nxt;
  logic [23:0] tick_cnt, tick_nxt;
  logic [7:0]  plane_y_nxt;
  logic [8:0]  y_dec, y_inc;

  // 9-bit arithmetic so a borrow or carry past the 8-bit range is visible
  assign y_dec = {1'b0, plane_y} - {1'b0, STEP};
  assign y_inc = {1'b0, plane_y} + {1'b0, STEP};

  always_comb begin
    state_nxt   = state;
    pix_nxt     = pix_cnt;
    tick_nxt    = tick_cnt;
    plane_y_nxt = plane_y;
    case (state)
      IDLE:   if (go) state_nxt = LOAD_D;
      LOAD_D: state_nxt = DRAW;
      DRAW: begin
        pix_nxt = pix_cnt + 4'd1;
        if (pix_cnt == 4'd15) state_nxt = WAIT;
      end
      WAIT: begin
        if (tick_cnt == FRAME_TICKS - 24'd1) begin
          tick_nxt  = 24'd0;
          state_nxt = LOAD_E;
        end else begin
          tick_nxt = tick_cnt + 24'd1;
        end
      end
      LOAD_E: state_nxt = ERASE;
      ERASE: begin
        pix_nxt = pix_cnt + 4'd1;
        if (pix_cnt == 4'd15) state_nxt = UPDATE;
      end
      UPDATE: begin
        if (up && !down)
          plane_y_nxt = (y_dec[8] || (y_dec < {1'b0, Y_MIN})) ? Y_MIN : y_dec[7:0];
        else if (down && !up)
          plane_y_nxt = (y_inc > {1'b0, Y_MAX}) ? Y_MAX : y_inc[7:0];
        state_nxt = go ? LOAD_D : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pix_cnt   <= 4'd0;
      tick_cnt  <= 24'd0;
      plane_y   <= Y_START;
      ld_x      <= 1'b0;
      ld_y      <= 1'b0;
      ld_color  <= 1'b0;
      dp_enable <= 1'b0;
      plot      <= 1'b0;
      x_in      <= 9'd0;
      y_in      <= 8'd0;
      color_in  <= 3'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pix_cnt   <= pix_nxt;
      tick_cnt  <= tick_nxt;
      plane_y   <= plane_y_nxt;
      ld_x      <= (state_nxt == LOAD_D);
      ld_y      <= (state_nxt == LOAD_D);
      ld_color  <= (state_nxt == LOAD_D) || (state_nxt == LOAD_E);
      dp_enable <= (state_nxt == DRAW) || (state_nxt == ERASE);
      plot      <= (state_nxt == DRAW) || (state_nxt == ERASE);
      busy      <= (state_nxt != IDLE);
      x_in      <= (state_nxt != IDLE) ? X_START : 9'd0;
      y_in      <= (state_nxt != IDLE) ? plane_y_nxt : 8'd0;
      color_in  <= (state_nxt == LOAD_D) ? PLANE_COLOR : 3'd0;
    end
  end

endmodule

// File: tb/tb_airplane_draw_ctrl.sv
// Directed bench for airplane_draw_ctrl with a behavioural sprite datapath model.
module tb_airplane_draw_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0, up = 1'b0, down = 1'b0;
  logic       ld_x, ld_y, ld_color, dp_enable, plot, busy;
  logic [8:0] x_in;
  logic [7:0] y_in, plane_y;
  logic [2:0] color_in;

  logic       go2 = 1'b0, up2 = 1'b0, down2 = 1'b0;
  logic       ld_x2, ld_y2, ld_color2, dp_enable2, plot2, busy2;
  logic [8:0] x_in2;
  logic [7:0] y_in2, plane_y2;
  logic [2:0] color_in2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  airplane_draw_ctrl #(.FRAME_TICKS(24'd4)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .up(up), .down(down),
    .ld_x(ld_x), .ld_y(ld_y), .ld_color(ld_color), .dp_enable(dp_enable),
    .plot(plot), .x_in(x_in), .y_in(y_in), .color_in(color_in),
    .busy(busy), .plane_y(plane_y)
  );

  airplane_draw_ctrl #(.Y_START(8'd1), .STEP(8'd2), .FRAME_TICKS(24'd4)) dut2 (
    .clk(clk), .reset_n(reset_n), .go(go2), .up(up2), .down(down2),
    .ld_x(ld_x2), .ld_y(ld_y2), .ld_color(ld_color2), .dp_enable(dp_enable2),
    .plot(plot2), .x_in(x_in2), .y_in(y_in2), .color_in(color_in2),
    .busy(busy2), .plane_y(plane_y2)
  );

  // Sprite datapath model: position/colour registers plus a 4-bit raster counter
  logic [8:0] dp_x;
  logic [7:0] dp_y;
  logic [2:0] dp_c;
  logic [3:0] dp_cnt;
  logic [8:0] x_out;
  logic [7:0] y_out;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_x <= 9'd0; dp_y <= 8'd0; dp_c <= 3'd0; dp_cnt <= 4'd0;
    end else begin
      if (ld_x) dp_x <= x_in;
      if (ld_y) dp_y <= y_in;
      if (ld_color) dp_c <= color_in;
      if (dp_enable) dp_cnt <= dp_cnt + 4'd1;
    end
  end
  assign x_out = dp_x + {7'd0, dp_cnt[1:0]};
  assign y_out = dp_y + {6'd0, dp_cnt[3:2]};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic go_val);
    @(negedge clk);
    reset_n = 1'b0; go = 1'b0; up = 1'b0; down = 1'b0;
    go2 = 1'b0; up2 = 1'b0; down2 = 1'b0;
    @(negedge clk);
    go = go_val;
    reset_n = 1'b1;
  endtask

  task automatic wait_frame_start(input logic second);
    int i;
    for (i = 0; i < 200; i++) begin
      step();
      if ((!second && ld_x) || (second && ld_x2)) break;
    end
    n_cmp++;
    if (i == 200) begin
      n_err++;
      $display("FAIL frame_start_timeout: no ld_x within %0d cycles, required one", i);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || plot !== 1'b0 || ld_x !== 1'b0 || plane_y !== 8'd56) begin
      n_err++;
      $display("FAIL reset_state: busy=%b plot=%b ld_x=%b plane_y=%0d, required 0 0 0 56",
               busy, plot, ld_x, plane_y);
    end
    do_reset(1'b1);
    repeat (4) step();
    n_cmp++;
    if (plot !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_draw: plot=%b, required 1", plot);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || plot !== 1'b0 || dp_enable !== 1'b0 || x_in !== 9'd0 ||
        y_in !== 8'd0 || plane_y !== 8'd56) begin
      n_err++;
      $display("FAIL reset_async: busy=%b plot=%b en=%b x_in=%0d y_in=%0d plane_y=%0d, required 0 0 0 0 0 56",
               busy, plot, dp_enable, x_in, y_in, plane_y);
    end
    go = 1'b0;
    #1 reset_n = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b0 || ld_x !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_hold: busy=%b ld_x=%b, required 0 0", busy, ld_x);
    end
  endtask

  task automatic test_frame_timing();
    int bad;
    int p;
    logic e_ld, e_ldc, e_plot;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [2:0] ec;
    do_reset(1'b1);
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      e_ld   = (c == 1) || (c == 40);
      e_ldc  = e_ld || (c == 22);
      e_plot = (c >= 2 && c <= 17) || (c >= 23 && c <= 38);
      if (ld_x !== e_ld || ld_y !== e_ld || ld_color !== e_ldc || plot !== e_plot ||
          dp_enable !== e_plot || busy !== 1'b1) begin
        bad++;
        $display("FAIL frame_strobes c=%0d: ld_x=%b ld_y=%b ld_c=%b plot=%b en=%b busy=%b, required %b %b %b %b %b 1",
                 c, ld_x, ld_y, ld_color, plot, dp_enable, busy, e_ld, e_ld, e_ldc, e_plot, e_plot);
      end
      if (e_plot) begin
        p  = (c <= 17) ? c - 2 : c - 23;
        ex = 9'd40 + 9'(p % 4);
        ey = 8'd56 + 8'(p / 4);
        ec = (c <= 17) ? 3'd7 : 3'd0;
        if (x_out !== ex || y_out !== ey || dp_c !== ec) begin
          bad++;
          $display("FAIL frame_pixel c=%0d: (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                   c, x_out, y_out, dp_c, ex, ey, ec);
        end
      end
      if (c == 1 && (x_in !== 9'd40 || y_in !== 8'd56 || color_in !== 3'd7)) begin
        bad++;
        $display("FAIL frame_load_d: x_in=%0d y_in=%0d color_in=%0d, required 40 56 7",
                 x_in, y_in, color_in);
      end
      if (c == 22 && (x_in !== 9'd40 || y_in !== 8'd56 || color_in !== 3'd0)) begin
        bad++;
        $display("FAIL frame_load_e: x_in=%0d y_in=%0d color_in=%0d, required 40 56 0",
                 x_in, y_in, color_in);
      end
      n_cmp++;
    end
    n_err += bad;
  endtask

  task automatic test_motion();
    logic [7:0] exp_y [0:3];
    exp_y[0] = 8'd56; exp_y[1] = 8'd55; exp_y[2] = 8'd54; exp_y[3] = 8'd53;
    do_reset(1'b1);
    up = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_frame_start(1'b0);
      n_cmp++;
      if (plane_y !== exp_y[f] || y_in !== exp_y[f]) begin
        n_err++;
        $display("FAIL motion_up f=%0d: plane_y=%0d y_in=%0d, required %0d", f, plane_y, y_in, exp_y[f]);
      end
    end
    down = 1'b1;
    wait_frame_start(1'b0);
    n_cmp++;
    if (plane_y !== 8'd53) begin
      n_err++;
      $display("FAIL motion_both: plane_y=%0d, required 53", plane_y);
    end
    up = 1'b0; down = 1'b0;
    wait_frame_start(1'b0);
    repeat (3) step();
    up = 1'b1;
    repeat (2) step();
    up = 1'b0;
    repeat (14) step();
    down = 1'b1;
    repeat (3) step();
    down = 1'b0;
    wait_frame_start(1'b0);
    n_cmp++;
    if (plane_y !== 8'd53) begin
      n_err++;
      $display("FAIL motion_pulse_ignored: plane_y=%0d, required 53", plane_y);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] exp_y [0:2];
    exp_y[0] = 8'd1; exp_y[1] = 8'd0; exp_y[2] = 8'd0;
    do_reset(1'b0);
    go2 = 1'b1; up2 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_frame_start(1'b1);
      n_cmp++;
      if (plane_y2 !== exp_y[f]) begin
        n_err++;
        $display("FAIL clamp_low f=%0d: plane_y=%0d, required %0d", f, plane_y2, exp_y[f]);
      end
    end
    up2 = 1'b0; down2 = 1'b1;
    for (int f = 0; f < 58; f++) wait_frame_start(1'b1);
    n_cmp++;
    if (plane_y2 !== 8'd116) begin
      n_err++;
      $display("FAIL clamp_reach_max: plane_y=%0d, required 116", plane_y2);
    end
    wait_frame_start(1'b1);
    n_cmp++;
    if (plane_y2 !== 8'd116) begin
      n_err++;
      $display("FAIL clamp_high: plane_y=%0d, required 116", plane_y2);
    end
    go2 = 1'b0; down2 = 1'b0;
  endtask

  task automatic test_stop();
    int erase_plots, bad_col, i;
    do_reset(1'b1);
    wait_frame_start(1'b0);
    repeat (18) step();
    go = 1'b0;
    erase_plots = 0; bad_col = 0;
    for (i = 0; i < 100; i++) begin
      step();
      if (plot) begin
        erase_plots++;
        if (dp_c !== 3'd0) bad_col++;
      end
      if (!busy) break;
    end
    n_cmp++;
    if (i == 100 || erase_plots != 16 || bad_col != 0) begin
      n_err++;
      $display("FAIL stop_erase: cycles=%0d erase_plots=%0d bad_colour=%0d, required <100 16 0",
               i, erase_plots, bad_col);
    end
    repeat (5) step();
    n_cmp++;
    if (busy !== 1'b0 || plot !== 1'b0 || ld_x !== 1'b0) begin
      n_err++;
      $display("FAIL stop_idle: busy=%b plot=%b ld_x=%b, required 0 0 0", busy, plot, ld_x);
    end
  endtask

  task automatic test_scoreboard();
    logic [8:0] dx [0:15];
    logic [7:0] dy [0:15];
    logic [7:0] py, ny;
    int nd, ne, bad;
    logic u, d;
    do_reset(1'b1);
    ny = 8'd56;
    for (int f = 0; f < 10; f++) begin
      wait_frame_start(1'b0);
      py = plane_y;
      n_cmp++;
      if (py !== ny) begin
        n_err++;
        $display("FAIL sb_plane_y f=%0d: plane_y=%0d, required %0d", f, py, ny);
      end
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      up = u; down = d;
      ny = ny;
      if (u && !d) ny = (ny == 8'd0) ? 8'd0 : ny - 8'd1;
      else if (d && !u) ny = (ny >= 8'd116) ? 8'd116 : ny + 8'd1;
      nd = 0; ne = 0; bad = 0;
      for (int c = 0; c < 38; c++) begin
        step();
        if (plot) begin
          if (x_out < 9'd40 || x_out > 9'd43 || y_out < ny - ny + py || y_out > py + 8'd3) bad++;
          if (dp_c == 3'd7 && nd < 16) begin
            dx[nd] = x_out; dy[nd] = y_out; nd++;
          end else if (dp_c == 3'd0 && ne < 16) begin
            if (dx[ne] !== x_out || dy[ne] !== y_out) bad++;
            ne++;
          end else begin
            bad++;
          end
        end
      end
      n_cmp++;
      if (nd != 16 || ne != 16 || bad != 0) begin
        n_err++;
        $display("FAIL sb_frame f=%0d: draws=%0d erases=%0d bad=%0d, required 16 16 0", f, nd, ne, bad);
      end
    end
    go = 1'b0; up = 1'b0; down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_motion();
    test_clamp();
    test_stop();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
